reg_trace_streamer: RTL and testbench

- Downstream consumer of the CPU top entity's debug register outputs.
- Captures a snapshot of the register taps plus a clock-cycle stamp on a capture strobe.
- Serialises the snapshot into a byte stream with a header and an XOR checksum, over a valid/ready interface.
- The stream feeds a UART or host bridge, replacing simulation-only $display tracing with a synthesizable trace path.

---
 rtl/reg_trace_streamer.sv | 183 ++++++++++++++++++
 tb/tb_reg_trace_streamer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/reg_trace_streamer.sv
// Register trace streamer: snapshots NUM_REGS 32-bit register taps plus a
// free-running cycle stamp on a capture strobe, then emits them as a byte
// frame over valid/ready:
//   HDR_BYTE, stamp[31:24..7:0], reg1..regN (big-endian), XOR checksum.
// Optional feature macro: TRACE_DELTA_EN. When defined, a capture whose taps
// equal the last transmitted snapshot is skipped silently.
module reg_trace_streamer #(
    parameter int unsigned NUM_REGS = 10,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     capture,
    input  logic [32*NUM_REGS-1:0]   regs_flat,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic [7:0]               drop_count,
    output logic [15:0]              frame_count
);

    localparam int unsigned RegIdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [RegIdxW-1:0] LastReg = RegIdxW'(NUM_REGS - 1);

    typedef enum logic [2:0] {StIdle, StHdr, StCyc, StReg, StSum} state_e;

    state_e                  state_q, state_d;
    logic [31:0]             cyc_q;
    logic [31:0]             stamp_q, stamp_d;
    logic [32*NUM_REGS-1:0]  snap_q, snap_d;
    logic [7:0]              csum_q, csum_d;
    logic [1:0]              byte_idx_q, byte_idx_d;
    logic [RegIdxW-1:0]      reg_idx_q, reg_idx_d;
    logic [7:0]              drop_q, drop_d;
    logic [15:0]             frame_q, frame_d;
    logic [31:0]             reg_word;
    logic                    xfer;
    logic                    accept;
    logic                    skip;

    // Big-endian byte pick: index 0 is the most significant byte.
    function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

`ifdef TRACE_DELTA_EN
    logic [32*NUM_REGS-1:0] shadow_q;

    // Shadow copy of the last fully transmitted snapshot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
        end else if (state_q == StSum && xfer) begin
            shadow_q <= snap_q;
        end
    end

    assign skip = (regs_flat == shadow_q);
`else
    assign skip = 1'b0;
`endif

    assign reg_word = snap_q[32*reg_idx_q +: 32];
    assign xfer     = out_valid && out_ready;
    assign accept   = capture && (state_q == StIdle) && !skip;

    // Outputs decode straight from state so reset clears them asynchronously.
    always_comb begin
        out_data  = 8'h00;
        out_valid = (state_q != StIdle);
        busy      = (state_q != StIdle);
        case (state_q)
            StHdr:   out_data = HDR_BYTE;
            StCyc:   out_data = be_byte(stamp_q, byte_idx_q);
            StReg:   out_data = be_byte(reg_word, byte_idx_q);
            StSum:   out_data = csum_q;
            default: out_data = 8'h00;
        endcase
    end

    // Next-state: frame sequencing, checksum, drop and frame counters.
    always_comb begin
        state_d    = state_q;
        stamp_d    = stamp_q;
        snap_d     = snap_q;
        csum_d     = csum_q;
        byte_idx_d = byte_idx_q;
        reg_idx_d  = reg_idx_q;
        drop_d     = drop_q;
        frame_d    = frame_q;

        // Any capture outside IDLE is rejected, including the final handshake edge.
        if (capture && state_q != StIdle && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end

        if (xfer) begin
            csum_d = csum_q ^ out_data;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    stamp_d    = cyc_q;
                    snap_d     = regs_flat;
                    csum_d     = 8'h00;
                    byte_idx_d = 2'd0;
                    reg_idx_d  = '0;
                    state_d    = StHdr;
                end
            end
            StHdr: begin
                if (xfer) begin
                    state_d = StCyc;
                end
            end
            StCyc: begin
                if (xfer) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = StReg;
                    end
                end
            end
            StReg: begin
                if (xfer) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        if (reg_idx_q == LastReg) begin
                            state_d = StSum;
                        end else begin
                            reg_idx_d = reg_idx_q + 1'b1;
                        end
                    end
                end
            end
            StSum: begin
                if (xfer) begin
                    state_d = StIdle;
                    frame_d = frame_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers and the free-running cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cyc_q      <= 32'd0;
            stamp_q    <= 32'd0;
            snap_q     <= '0;
            csum_q     <= 8'h00;
            byte_idx_q <= 2'd0;
            reg_idx_q  <= '0;
            drop_q     <= 8'h00;
            frame_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_q + 32'd1;
            stamp_q    <= stamp_d;
            snap_q     <= snap_d;
            csum_q     <= csum_d;
            byte_idx_q <= byte_idx_d;
            reg_idx_q  <= reg_idx_d;
            drop_q     <= drop_d;
            frame_q    <= frame_d;
        end
    end

    assign drop_count  = drop_q;
    assign frame_count = frame_q;

endmodule

// File: tb/tb_reg_trace_streamer.sv
// Directed bench for reg_trace_streamer (default build, NUM_REGS=2, 14-byte frames).
module tb_reg_trace_streamer;

    localparam int unsigned NR = 2;
    localparam int FL = 6 + 4 * NR;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           capture = 1'b0;
    logic           out_ready = 1'b0;
    logic [32*NR-1:0] regs_flat = '0;
    logic [7:0]     out_data;
    logic           out_valid;
    logic           busy;
    logic [7:0]     drop_count;
    logic [15:0]    frame_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] tb_cyc;
    logic [7:0]  exp_b [FL];

    reg_trace_streamer #(
        .NUM_REGS (NR),
        .HDR_BYTE (8'hA5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .capture     (capture),
        .regs_flat   (regs_flat),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .drop_count  (drop_count),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    // Edges seen since reset release; equals the stamp a capture on the next edge latches.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_cyc <= 32'd0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic build(input logic [31:0] stamp, input logic [32*NR-1:0] regs);
        logic [7:0] x;
        exp_b[0] = 8'hA5;
        for (int b = 0; b < 4; b++) exp_b[1+b] = stamp[31-8*b -: 8];
        for (int r = 0; r < int'(NR); r++)
            for (int b = 0; b < 4; b++) exp_b[5+4*r+b] = regs[32*r+31-8*b -: 8];
        x = 8'h00;
        for (int i = 0; i < FL - 1; i++) x = x ^ exp_b[i];
        exp_b[FL-1] = x;
    endtask

    // Receive one frame, optionally stalling with ready pattern 1,0,0,1 and
    // optionally corrupting the live taps once byte flip_at is being offered.
    task automatic drain(input string tag, input bit stall, input int flip_at);
        int got;
        got = 0;
        for (int k = 0; k < 200 && got < FL; k++) begin
            out_ready = stall ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            if (got == flip_at) regs_flat = '1;
            check({tag, " valid"}, 32'(out_valid), 32'd1);
            check({tag, " byte"}, 32'(out_data), 32'(exp_b[got]));
            if (out_ready) got++;
            step();
        end
        check({tag, " length"}, 32'(got), 32'(FL));
        check({tag, " done busy"}, 32'(busy), 32'd0);
        check({tag, " done valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst valid", 32'(out_valid), 32'd0);
        check("rst data", 32'(out_data), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst drop", 32'(drop_count), 32'd0);
        check("rst frames", 32'(frame_count), 32'd0);
        reset = 1'b1;

        // Frame 1: capture on the 4th edge after release, stamp 3, hand-computed bytes.
        regs_flat = 64'h9ABCDEF0_12345678;
        out_ready = 1'b1;
        repeat (3) step();
        capture = 1'b1;
        exp_b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h03, 8'h12, 8'h34,
                  8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hA6};
        step();
        capture = 1'b0;
        check("f1 busy", 32'(busy), 32'd1);
        drain("f1", 1'b0, -1);
        check("f1 frames", 32'(frame_count), 32'd1);
        check("f1 drops", 32'(drop_count), 32'd0);

        // Ready is ignored while idle.
        out_ready = 1'b1;
        repeat (3) step();
        check("idle valid", 32'(out_valid), 32'd0);
        check("idle frames", 32'(frame_count), 32'd1);

        // Frame 2: stalled handshake, data held stable across stalls.
        regs_flat = 64'hCAFEF00D_0BADBEEF;
        capture = 1'b1;
        build(tb_cyc, regs_flat);
        step();
        capture = 1'b0;
        drain("f2", 1'b1, -1);
        check("f2 frames", 32'(frame_count), 32'd2);

        // Frame 3: capture held through the final checksum edge: 1 accept, 14 drops.
        regs_flat = 64'h01020304_05060708;
        capture = 1'b1;
        build(tb_cyc, regs_flat);
        step();
        drain("f3", 1'b0, -1);
        capture = 1'b0;
        check("f3 drops", 32'(drop_count), 32'd14);
        check("f3 frames", 32'(frame_count), 32'd3);
        step();
        check("f3 no restart", 32'(busy), 32'd0);

        // Frame 4: taps change mid-frame, snapshot still transmitted.
        regs_flat = 64'h11111111_11111111;
        capture = 1'b1;
        build(tb_cyc, regs_flat);
        step();
        capture = 1'b0;
        drain("f4", 1'b0, 7);
        check("f4 frames", 32'(frame_count), 32'd4);

        // Reset while in the register phase.
        regs_flat = 64'h11223344_55667788;
        capture = 1'b1;
        build(tb_cyc, regs_flat);
        step();
        capture = 1'b0;
        out_ready = 1'b1;
        repeat (7) step();
        check("mid byte", 32'(out_data), 32'(exp_b[7]));
        #2;
        reset = 1'b0;
        #1;
        check("mrst valid", 32'(out_valid), 32'd0);
        check("mrst busy", 32'(busy), 32'd0);
        check("mrst data", 32'(out_data), 32'd0);
        check("mrst drop", 32'(drop_count), 32'd0);
        check("mrst frames", 32'(frame_count), 32'd0);
        #1;
        reset = 1'b1;
        repeat (2) step();
        capture = 1'b1;
        build(32'd2, regs_flat);
        step();
        capture = 1'b0;
        drain("f5", 1'b0, -1);
        check("f5 frames", 32'(frame_count), 32'd1);
        check("f5 drops", 32'(drop_count), 32'd0);

        // Drop counter saturation during a long stall.
        regs_flat = 64'h0F0F0F0F_F0F0F0F0;
        capture = 1'b1;
        build(tb_cyc, regs_flat);
        step();
        out_ready = 1'b0;
        repeat (300) step();
        capture = 1'b0;
        check("sat drop", 32'(drop_count), 32'd255);
        check("sat hold", 32'(out_data), 32'h000000A5);
        drain("f6", 1'b0, -1);
        check("f6 frames", 32'(frame_count), 32'd2);
        check("f6 drop held", 32'(drop_count), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
